anton_neopixel_frame_loader: RTL and testbench
==============================================

ANTON_NEOPIXEL_FRAME_LOADER -- requirements
Module: anton_neopixel_frame_loader

Interface
REQ-001 SHALL have parameter BUFFER_END, default `BUFFER_END_DEFAULT, last valid raw-buffer index; legal range 0..8191.
REQ-002 SHALL have localparam BUFFER_BITS = `CLOG2(BUFFER_END+1), pixel index counter width.
REQ-003 busClk  input  1  sole clock; all state on rising edge.
REQ-004 busReset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to load and launch a frame; ignored unless IDLE.
REQ-006 cfgLimit, cfgLoop, cfg32bit  input  1 each  control bits for the CTRL register, latched on accepted start.
REQ-007 streamData  input  8  pixel byte; streamValid  input  1; streamLast  input  1 marks final byte; streamReady  output  1.
REQ-008 busAddr  output  18  bus address; busDataIn  output  8  write data; busWrite  output  1; busRead  output  1.
REQ-009 busDataOut  input  8  registered read data, valid the cycle after busRead.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after CTRL write issued.
REQ-012 overflow  output  1  sticky: frame truncated at BUFFER_END; cleared on accepted start.

Function
REQ-013 SHALL register busAddr, busDataIn, busWrite, busRead; busWrite and busRead never high together, each high for exactly one cycle per transaction.
REQ-014 FSM states IDLE, POLL_REQ, POLL_WAIT, LOAD, MAX_LO, MAX_HI, CTRL, DONE.
REQ-015 IDLE: start -> latch cfg bits, index=0, overflow=0, go POLL_REQ.
REQ-016 POLL_REQ: drive busRead=1, busAddr=18'h30003 for one cycle; go POLL_WAIT.
REQ-017 POLL_WAIT: sample busDataOut[0]; 1 (streamer running) -> POLL_REQ; 0 -> LOAD.
REQ-018 LOAD: streamReady=1 combinationally; streamReady=0 in all other states.
REQ-019 Each accepted byte (streamValid & streamReady) in cycle N SHALL produce busWrite=1, busAddr={2'b10, index zero-extended to 16 bits}, busDataIn=streamData in cycle N+1; index increments; sustained one write per cycle.
REQ-020 Accepted byte with streamLast=1 -> lastIx=index, go MAX_LO.
REQ-021 Accepted byte with index==BUFFER_END and streamLast=0 -> lastIx=BUFFER_END, overflow=1, go MAX_LO; remaining stream bytes not accepted.
REQ-022 streamLast and index==BUFFER_END on same byte -> normal termination, overflow stays 0.
REQ-023 MAX_LO: write addr 18'h30000, data lastIx[7:0]. MAX_HI: write 18'h30001, data {3'b000, lastIx[12:8]}, lastIx zero-extended to 13 bits.
REQ-024 CTRL: write 18'h30002, data {3'b000, cfg32bit, cfgLoop, 1'b1, cfgLimit, 1'b0} (Run set, Init clear).
REQ-025 DONE: done=1 one cycle; next state IDLE.
REQ-026 MAX_LO, MAX_HI, CTRL each last exactly one cycle; writes on consecutive cycles.
REQ-027 start outside IDLE SHALL be ignored with no effect on latched cfg or overflow.
REQ-028 streamValid without streamReady SHALL not change index or bus outputs.

Reset
REQ-029 busReset high SHALL immediately force IDLE, index=0, lastIx=0, cfg latches=0, all outputs 0 (busAddr=0, busDataIn=0, overflow=0).
REQ-030 Reset mid-LOAD or mid-register-write SHALL abort with no further bus transaction; frame not launched.
REQ-031 After reset release, first transaction only after a new start.

Verification
REQ-032 BUFFER_END=7, busDataOut[0]=0, start, cfgLoop=1, stream 3 bytes A1,B2,C3 (last on C3) -> writes 20000=A1, 20001=B2, 20002=C3, 30000=02, 30001=00, 30002=0x0C, done pulse, overflow=0.
REQ-033 busDataOut[0]=1 for 3 polls then 0 -> exactly 4 busRead pulses at 30003 before first streamReady.
REQ-034 BUFFER_END=7, stream 10 bytes without last -> 8 raw writes 20000..20007, 30000=07, overflow=1, bytes 9-10 not accepted.
REQ-035 Single byte 5A with last, cfg32bit=1, cfgLimit=1 -> 20000=5A, 30000=00, 30001=00, 30002=0x16.
REQ-036 streamValid toggling every other cycle -> writes contiguous in address, gaps in time, data order preserved.
REQ-037 busReset asserted after 2 of 4 bytes -> all outputs 0 same cycle, no 3000x writes, start re-issued later runs normally.

Source files
------------

// File: rtl/anton_neopixel_frame_loader.sv
// ============================================================================
// anton_neopixel_frame_loader : streams pixel bytes into the NeoPixel raw
// buffer, then programs MAX_LO/MAX_HI/CTRL to launch the frame.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 8191
`endif
`ifndef CLOG2
`define CLOG2(x) (((x) <= 2) ? 1 : $clog2(x))
`endif

module anton_neopixel_frame_loader #(
  parameter int BUFFER_END = `BUFFER_END_DEFAULT
) (
  input  logic        busClk,
  input  logic        busReset,
  input  logic        start,
  input  logic        cfgLimit,
  input  logic        cfgLoop,
  input  logic        cfg32bit,
  input  logic [7:0]  streamData,
  input  logic        streamValid,
  input  logic        streamLast,
  output logic        streamReady,
  output logic [17:0] busAddr,
  output logic [7:0]  busDataIn,
  output logic        busWrite,
  output logic        busRead,
  input  logic [7:0]  busDataOut,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int BUFFER_BITS = `CLOG2(BUFFER_END + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_POLL_REQ  = 3'd1;
  localparam logic [2:0] S_POLL_WAIT = 3'd2;
  localparam logic [2:0] S_LOAD      = 3'd3;
  localparam logic [2:0] S_MAX_LO    = 3'd4;
  localparam logic [2:0] S_MAX_HI    = 3'd5;
  localparam logic [2:0] S_CTRL      = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam logic [17:0] ADDR_MAX_LO = 18'h30000;
  localparam logic [17:0] ADDR_MAX_HI = 18'h30001;
  localparam logic [17:0] ADDR_CTRL   = 18'h30002;
  localparam logic [17:0] ADDR_STATUS = 18'h30003;

  logic [2:0]             r_state;
  logic [2:0]             w_next;
  logic [BUFFER_BITS-1:0] r_index;
  logic [12:0]            r_lastIx;
  logic                   r_cfgLimit;
  logic                   r_cfgLoop;
  logic                   r_cfg32bit;
  logic                   r_overflow;
  logic [17:0]            r_busAddr;
  logic [7:0]             r_busDataIn;
  logic                   r_busWrite;
  logic                   r_busRead;
  logic                   w_accept;
  logic                   w_atEnd;
  logic                   w_unused_bits;

  assign w_accept      = streamValid & streamReady;
  assign w_atEnd       = (r_index == BUFFER_BITS'(BUFFER_END));
  assign w_unused_bits = ^busDataOut[7:1];

  assign busAddr   = r_busAddr;
  assign busDataIn = r_busDataIn;
  assign busWrite  = r_busWrite;
  assign busRead   = r_busRead;
  assign overflow  = r_overflow;

  always_ff @(posedge busClk or posedge busReset) begin
    if (busReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = S_POLL_REQ;
      S_POLL_REQ:  w_next = S_POLL_WAIT;
      S_POLL_WAIT: w_next = busDataOut[0] ? S_POLL_REQ : S_LOAD;
      S_LOAD:      if (w_accept && (streamLast || w_atEnd)) w_next = S_MAX_LO;
      S_MAX_LO:    w_next = S_MAX_HI;
      S_MAX_HI:    w_next = S_CTRL;
      S_CTRL:      w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    streamReady = (r_state == S_LOAD);
  end

  // Bus strobes are registered, so each transaction appears the cycle after
  // the state that issues it; address/data hold between transactions.
  always_ff @(posedge busClk or posedge busReset) begin
    if (busReset) begin
      r_index     <= '0;
      r_lastIx    <= '0;
      r_cfgLimit  <= 1'b0;
      r_cfgLoop   <= 1'b0;
      r_cfg32bit  <= 1'b0;
      r_overflow  <= 1'b0;
      r_busAddr   <= '0;
      r_busDataIn <= '0;
      r_busWrite  <= 1'b0;
      r_busRead   <= 1'b0;
    end else begin
      r_busWrite <= 1'b0;
      r_busRead  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cfgLimit <= cfgLimit;
            r_cfgLoop  <= cfgLoop;
            r_cfg32bit <= cfg32bit;
            r_index    <= '0;
            r_overflow <= 1'b0;
            r_busRead  <= 1'b1;
            r_busAddr  <= ADDR_STATUS;
          end
        end
        S_POLL_WAIT: begin
          if (busDataOut[0]) begin
            r_busRead <= 1'b1;
            r_busAddr <= ADDR_STATUS;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_busWrite  <= 1'b1;
            r_busAddr   <= {2'b10, 16'(r_index)};
            r_busDataIn <= streamData;
            r_index     <= r_index + BUFFER_BITS'(1);
            if (streamLast) begin
              r_lastIx <= 13'(r_index);
            end else if (w_atEnd) begin
              r_lastIx   <= 13'(BUFFER_END);
              r_overflow <= 1'b1;
            end
          end
        end
        S_MAX_LO: begin
          r_busWrite  <= 1'b1;
          r_busAddr   <= ADDR_MAX_LO;
          r_busDataIn <= r_lastIx[7:0];
        end
        S_MAX_HI: begin
          r_busWrite  <= 1'b1;
          r_busAddr   <= ADDR_MAX_HI;
          r_busDataIn <= {3'b000, r_lastIx[12:8]};
        end
        S_CTRL: begin
          r_busWrite  <= 1'b1;
          r_busAddr   <= ADDR_CTRL;
          r_busDataIn <= {3'b000, r_cfg32bit, r_cfgLoop, 1'b1, r_cfgLimit, 1'b0};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_anton_neopixel_frame_loader.sv
// ============================================================================
// tb_anton_neopixel_frame_loader : randomized frames checked against an
// expected bus-transaction queue derived from the frame description.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_anton_neopixel_frame_loader;

  localparam int BE = 7;

  logic        busClk = 1'b0;
  logic        busReset = 1'b1;
  logic        start = 1'b0;
  logic        cfgLimit = 1'b0;
  logic        cfgLoop = 1'b0;
  logic        cfg32bit = 1'b0;
  logic [7:0]  streamData = 8'h00;
  logic        streamValid = 1'b0;
  logic        streamLast = 1'b0;
  logic        streamReady;
  logic [17:0] busAddr;
  logic [7:0]  busDataIn;
  logic        busWrite;
  logic        busRead;
  logic [7:0]  busDataOut = 8'h00;
  logic        busy;
  logic        done;
  logic        overflow;

  anton_neopixel_frame_loader #(.BUFFER_END(BE)) dut (
    .busClk(busClk), .busReset(busReset), .start(start),
    .cfgLimit(cfgLimit), .cfgLoop(cfgLoop), .cfg32bit(cfg32bit),
    .streamData(streamData), .streamValid(streamValid), .streamLast(streamLast),
    .streamReady(streamReady), .busAddr(busAddr), .busDataIn(busDataIn),
    .busWrite(busWrite), .busRead(busRead), .busDataOut(busDataOut),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 busClk = ~busClk;

  typedef struct packed {
    logic        wr;
    logic [17:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t       exp_q[$];
  txn_t       t;
  logic [7:0] frame_bytes[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         polls_left = 0;
  int         done_cnt = 0;
  int         rd_cnt = 0;
  logic       prev_done = 1'b0;
  logic [7:0] seen_ctrl = 8'h00;
  logic [7:0] seen_maxlo = 8'h00;
  logic [7:0] seen_maxhi = 8'h00;
  logic [7:0] seen_raw2 = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Streamer status register: reports "running" for polls_left reads.
  always @(posedge busClk) begin
    if (busRead && busAddr == 18'h30003) begin
      busDataOut <= {7'd0, (polls_left > 0)};
      if (polls_left > 0) polls_left <= polls_left - 1;
    end else begin
      busDataOut <= 8'h00;
    end
  end

  always @(negedge busClk) begin
    if (busReset) begin
      prev_done = 1'b0;
    end else begin
      if (busWrite || busRead) begin
        chk("wr_rd_exclusive", 32'(busWrite & busRead), 32'd0);
        if (busRead) rd_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_txn: actual wr=%0d rd=%0d addr=%h required=no transaction",
                   busWrite, busRead, busAddr);
        end else begin
          t = exp_q.pop_front();
          chk("txn_kind_wr", 32'(busWrite), 32'(t.wr));
          chk("txn_addr", 32'(busAddr), 32'(t.addr));
          if (t.wr) chk("txn_data", 32'(busDataIn), 32'(t.data));
        end
        if (busWrite && busAddr == 18'h30002) seen_ctrl = busDataIn;
        if (busWrite && busAddr == 18'h30000) seen_maxlo = busDataIn;
        if (busWrite && busAddr == 18'h30001) seen_maxhi = busDataIn;
        if (busWrite && busAddr == 18'h20002) seen_raw2 = busDataIn;
      end
      if (streamReady && exp_q.size() > 0 && !exp_q[0].wr)
        chk("ready_before_polls_done", 32'(streamReady), 32'd0);
      if (done) begin
        done_cnt++;
        chk("done_single_cycle", 32'(prev_done), 32'd0);
      end
      prev_done = done;
    end
  end

  task automatic fill_random(input int len);
    frame_bytes.delete();
    for (int k = 0; k < len; k++) frame_bytes.push_back(8'($urandom));
  endtask

  // gap_mode: 0 = back-to-back, 1 = valid every other cycle, 2 = random gaps.
  task automatic run_frame(input int polls, input bit b32, input bit loop, input bit lim,
                           input int gap_mode, input bit noise);
    int   len = frame_bytes.size();
    int   n_acc = (len > BE + 1) ? BE + 1 : len;
    bit   ovf = (len > BE + 1);
    int   last_ix = n_acc - 1;
    int   d0 = done_cnt;
    int   i = 0;
    int   cyc = 0;
    int   n_got = 0;
    int   w = 0;
    bit   acc;
    bit   stopped;
    bit   give;
    for (int p = 0; p <= polls; p++) exp_q.push_back({1'b0, 18'h30003, 8'h00});
    for (int k = 0; k < n_acc; k++) exp_q.push_back({1'b1, 18'(18'h20000 + k), frame_bytes[k]});
    exp_q.push_back({1'b1, 18'h30000, 8'(last_ix & 8'hFF)});
    exp_q.push_back({1'b1, 18'h30001, 8'((last_ix >> 8) & 8'h1F)});
    exp_q.push_back({1'b1, 18'h30002, {3'b000, b32, loop, 1'b1, lim, 1'b0}});
    polls_left = polls;
    cfg32bit = b32; cfgLoop = loop; cfgLimit = lim;
    start = 1'b1;
    @(posedge busClk); #1;
    start = 1'b0;
    chk("overflow_cleared_on_start", 32'(overflow), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    if (noise) begin
      cfg32bit = ~b32; cfgLoop = ~loop; cfgLimit = ~lim;
    end
    while (i < len && cyc < 300) begin
      give = (gap_mode == 0) || (gap_mode == 1 && (cyc % 2) == 0) ||
             (gap_mode == 2 && $urandom_range(0, 2) != 0);
      streamValid = give;
      streamData  = frame_bytes[i];
      streamLast  = (i == len - 1);
      if (noise && streamReady && $urandom_range(0, 3) == 0) start = 1'b1;
      @(negedge busClk);
      acc = streamValid && streamReady;
      stopped = !busy;
      @(posedge busClk); #1;
      start = 1'b0;
      if (acc) begin
        i++;
        n_got++;
      end
      if (stopped) break;
      cyc++;
    end
    streamValid = 1'b0;
    streamLast  = 1'b0;
    while (done_cnt == d0 && w < 100) begin
      @(posedge busClk); #1;
      w++;
    end
    @(posedge busClk); #1;
    chk("frame_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("accepted_bytes", 32'(n_got), 32'(n_acc));
    chk("expected_txns_left", 32'(exp_q.size()), 32'd0);
    chk("overflow_flag", 32'(overflow), 32'(ovf));
    chk("idle_not_busy", 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busAddr"}, 32'(busAddr), 32'd0);
    chk({tag, "_busDataIn"}, 32'(busDataIn), 32'd0);
    chk({tag, "_strobes"}, 32'({busWrite, busRead}), 32'd0);
    chk({tag, "_flags"}, 32'({busy, done, overflow, streamReady}), 32'd0);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    @(posedge busClk); #1;
    busReset = 1'b0;
    repeat (3) @(posedge busClk);
    #1;

    // A1,B2,C3 with loop set
    frame_bytes.delete();
    frame_bytes.push_back(8'hA1); frame_bytes.push_back(8'hB2); frame_bytes.push_back(8'hC3);
    run_frame(0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    chk("lit_raw2", 32'(seen_raw2), 32'hC3);
    chk("lit_maxlo_02", 32'(seen_maxlo), 32'h02);
    chk("lit_maxhi_00", 32'(seen_maxhi), 32'h00);
    chk("lit_ctrl_0C", 32'(seen_ctrl), 32'h0C);

    // three busy polls before the streamer is free
    rd_cnt = 0;
    fill_random(4);
    run_frame(3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("lit_poll_reads_4", 32'(rd_cnt), 32'd4);

    // ten bytes into an eight-entry buffer
    fill_random(10);
    run_frame(0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    chk("lit_overflow_maxlo_07", 32'(seen_maxlo), 32'h07);
    chk("lit_overflow_sticky", 32'(overflow), 32'd1);

    // single byte, 32-bit and limit modes
    frame_bytes.delete();
    frame_bytes.push_back(8'h5A);
    run_frame(0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    chk("lit_single_maxlo_00", 32'(seen_maxlo), 32'h00);
    chk("lit_ctrl_16", 32'(seen_ctrl), 32'h16);

    // exactly full buffer with last on the final slot
    fill_random(BE + 1);
    run_frame(1, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    chk("lit_full_maxlo_07", 32'(seen_maxlo), 32'h07);

    // valid toggling every other cycle
    fill_random(5);
    run_frame(0, 1'b1, 1'b1, 1'b0, 1, 1'b1);

    // reset after two of four bytes
    fill_random(4);
    exp_q.push_back({1'b0, 18'h30003, 8'h00});
    exp_q.push_back({1'b1, 18'h20000, frame_bytes[0]});
    exp_q.push_back({1'b1, 18'h20001, frame_bytes[1]});
    begin
      int i = 0;
      int cyc = 0;
      bit acc;
      polls_left = 0;
      cfgLoop = 1'b1;
      start = 1'b1;
      @(posedge busClk); #1;
      start = 1'b0;
      while (i < 2 && cyc < 50) begin
        streamValid = 1'b1;
        streamData = frame_bytes[i];
        streamLast = 1'b0;
        @(negedge busClk);
        acc = streamReady;
        @(posedge busClk); #1;
        if (acc) i++;
        cyc++;
      end
      chk("reset_test_bytes_accepted", 32'(i), 32'd2);
      #1;
      busReset = 1'b1;
      #1;
      check_all_zero("midframe_reset");
      streamValid = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge busClk);
      #1;
      busReset = 1'b0;
      repeat (10) @(posedge busClk);
      #1;
      chk("idle_after_reset_release", 32'({busy, done}), 32'd0);
    end
    fill_random(3);
    run_frame(0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      fill_random($urandom_range(1, 11));
      run_frame($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom), 2, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
